z_move_sequencer: RTL and testbench
===================================

# z_move_sequencer

Command sequencer directly upstream of the Z-axis stepper driver. Buffers relative move commands (signed step count plus half-period speed) in a small FIFO and presents them one at a time on the stepper's `stepper_step_in`/`stepper_speed`/`start_driving` interface using that driver's level handshake. Detects endstop-blocked launches and tracks absolute Z position from the driver's remaining-step feedback.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two, at least 2.
- `ACK_TIMEOUT`, default 3: cycles to wait for `stepper_driving` to rise before declaring a block.
- `HOME_MAX_STEPS`, default 31'h00FF_FFFF: homing travel magnitude.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_steps` in 32: two's-complement relative steps; bit 31 is direction.
- `cmd_speed` in 32: clocks per step half-period.
- `cmd_home` in 1: homing command (see Configuration).
- `stepper_step_in` out 32: to driver.
- `stepper_speed` out 32: to driver.
- `start_driving` out 1: to driver.
- `stepper_driving` in 1: from driver.
- `stepper_step_out` in 32: driver's remaining signed steps.
- `zmin`, `zmax` in 1: endstops, used only for status/homing.
- `busy` out 1: FSM not IDLE or FIFO not empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupancy.
- `z_position` out 32: signed absolute position.
- `blocked_err` out 1: one-cycle pulse when a launch was refused.
- `home_fail` out 1: sticky flag, cleared by the next accepted command.

## Operation
- Reset: all outputs are 0, `cmd_ready` is 1, and the FIFO is empty.
- FIFO write happens on `cmd_valid & cmd_ready`. A simultaneous read and write while full is not allowed, because `cmd_ready` is already 0.
- FIFO entry is {home, steps, speed}. `cmd_speed==0` is stored as 1.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the entry into the active registers and go to CHECK.
  - CHECK: if steps[30:0]==0 (this includes 0x8000_0000), drop the command with no position change and return to IDLE. Otherwise drive the outputs and go to ISSUE.
  - ISSUE: `start_driving`=1 with the count loaded to ACK_TIMEOUT. Go to RUN when `stepper_driving`==1. If the count expires first, go to BLOCK.
  - RUN: hold `start_driving`=1 until `stepper_driving`==0, then go to DONE.
  - DONE: `z_position += active_steps - stepper_step_out` (32-bit wrap). Go to RELEASE.
  - BLOCK: pulse `blocked_err`, leave position unchanged, go to RELEASE.
  - RELEASE: `start_driving`=0 for exactly one cycle so the driver re-arms, then go to IDLE.
- `stepper_step_in` and `stepper_speed` are stable from CHECK through RELEASE.
- Reset mid-move: `start_driving` drops immediately, which stops the driver. Position is cleared and the FIFO is flushed.

## Timing
- Command accepted into an empty, idle block: `start_driving` rises 3 cycles after the write edge (FIFO, IDLE, CHECK).
- The driver sets `stepper_driving` one cycle after it samples `start_driving`, so a normal ack arrives on the 2nd ISSUE cycle.
- End of move to next launch: minimum 4 cycles (DONE, RELEASE, IDLE, CHECK).
- `z_position` updates the cycle after DONE is entered.
- `cmd_ready` depends combinationally on FIFO level only.

## Configuration
- With `Z_HOMING_EN` defined, an entry with home=1 issues steps = -HOME_MAX_STEPS at its speed. Negative steps move toward zmin, and the driver halts on zmin. At DONE or BLOCK:
  - If `zmin`==1: `z_position`:=0 and no `blocked_err` pulse (a block while already at zmin counts as home).
  - Else: set `home_fail`.
- Without `Z_HOMING_EN`, `cmd_home` is ignored, the entry is treated as a normal move, and `home_fail` is constant 0.

## Structure
- Shared package `stepper_pkg`: FSM state enum, command-entry struct {home, steps[31:0], speed[31:0]}, and the `STEP_DIR_BIT`=31 constant.
- Sub-module `cmd_fifo`: a synchronous FIFO parameterised on width and depth, with level output. Reusable for the X and Y sequencers.

## Test plan
- Move +100 at speed 2, driver model steps normally: `start_driving` rises 3 cycles after the write and falls for 1 cycle after `stepper_driving` falls; `z_position`=100.
- Move -50 with `zmin` asserting after 20 steps: driver stops early with `stepper_step_out`=-30; `z_position`=-20.
- Move +10 while `zmax`=1, so the driver never acks: `blocked_err` pulses once after 3 ISSUE cycles, `z_position` is unchanged, and the next command proceeds.
- Five back-to-back writes with FIFO_DEPTH=4: `cmd_ready` goes low after the 4th write and before the first pop. All five execute in order with `z_position` equal to their sum.
- Commands with steps 0 and 0x8000_0000: both are consumed and `start_driving` never rises.
- With `Z_HOMING_EN`, a home command from `z_position`=500: `zmin` asserts after 40 steps, giving `z_position`=0 and `home_fail`=0. Repeat with `zmin` never asserting: `home_fail`=1.

Source files
------------

// File: rtl/stepper_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stepper_pkg                                                      |
// | Shared types for the axis move sequencers.                       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package stepper_pkg;

   localparam int STEP_DIR_BIT = 31;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_RUN     = 3'd3,
      ST_DONE    = 3'd4,
      ST_BLOCK   = 3'd5,
      ST_RELEASE = 3'd6
   } seq_state_t;

   typedef struct packed {
      logic        home;
      logic [31:0] steps;
      logic [31:0] speed;
   } cmd_entry_t;

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmd_fifo                                                         |
// | Synchronous show-ahead FIFO with occupancy output.               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cmd_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      w_level;
   logic             w_do_wr;
   logic             w_do_rd;

   // Pointers carry one extra wrap bit so full and empty stay distinct.
   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign o_level   = w_level;
   assign o_full    = (w_level == (AW+1)'(DEPTH));
   assign o_empty   = (w_level == '0);
   assign w_do_wr   = i_wr_en & ~o_full;
   assign w_do_rd   = i_rd_en & ~o_empty;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/z_move_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | z_move_sequencer                                                 |
// | Buffers relative Z moves and launches them on the stepper driver;|
// | tracks absolute position. Optional homing via Z_HOMING_EN.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module z_move_sequencer
   import stepper_pkg::*;
#(
   parameter int          FIFO_DEPTH     = 4,
   parameter int          ACK_TIMEOUT    = 3,
   parameter logic [30:0] HOME_MAX_STEPS = 31'h00FF_FFFF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [31:0]                   cmd_steps,
   input  logic [31:0]                   cmd_speed,
   input  logic                          cmd_home,
   output logic [31:0]                   stepper_step_in,
   output logic [31:0]                   stepper_speed,
   output logic                          start_driving,
   input  logic                          stepper_driving,
   input  logic [31:0]                   stepper_step_out,
   input  logic                          zmin,
   input  logic                          zmax,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   z_position,
   output logic                          blocked_err,
   output logic                          home_fail
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   seq_state_t  r_state;
   seq_state_t  w_state_nxt;
   cmd_entry_t  w_wr_entry;
   cmd_entry_t  w_rd_entry;
   logic        w_full;
   logic        w_empty;
   logic        w_wr;
   logic        w_pop;
   logic        w_wr_home;
   logic        w_home_hit;
   logic        w_home_miss;
   logic [31:0] w_pop_steps;
   logic [31:0] r_act_steps;
   logic [31:0] r_act_speed;
   logic [CW-1:0] r_ack_cnt;
   logic [31:0] r_z;

   assign cmd_ready = ~w_full;
   assign w_wr      = cmd_valid & cmd_ready;

   always_comb begin
      w_wr_entry       = '0;
      w_wr_entry.home  = w_wr_home;
      w_wr_entry.steps = cmd_steps;
      w_wr_entry.speed = (cmd_speed == 32'd0) ? 32'd1 : cmd_speed;
   end

   cmd_fifo #(
      .WIDTH (65),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr),
      .i_wr_data (w_wr_entry),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_entry),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

`ifdef Z_HOMING_EN
   localparam logic [31:0] c_HOME_STEPS = 32'd0 - {1'b0, HOME_MAX_STEPS};

   logic r_act_home;
   logic r_home_fail;
   logic w_unused;

   assign w_wr_home   = cmd_home;
   assign w_pop_steps = w_rd_entry.home ? c_HOME_STEPS : w_rd_entry.steps;
   assign w_home_hit  = r_act_home & zmin;
   assign w_home_miss = r_act_home & ~zmin;
   assign home_fail   = r_home_fail;
   assign w_unused    = zmax;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_home  <= 1'b0;
         r_home_fail <= 1'b0;
      end else begin
         if (w_pop) r_act_home <= w_rd_entry.home;
         // A failure raised this cycle outranks a clear from a new command.
         if (w_home_miss && (r_state == ST_DONE || r_state == ST_BLOCK))
            r_home_fail <= 1'b1;
         else if (w_wr)
            r_home_fail <= 1'b0;
      end
   end
`else
   logic w_unused;

   assign w_wr_home   = 1'b0;
   assign w_pop_steps = w_rd_entry.steps;
   assign w_home_hit  = 1'b0;
   assign w_home_miss = 1'b0;
   assign home_fail   = 1'b0;
   assign w_unused    = zmax ^ zmin ^ cmd_home ^ w_rd_entry.home ^ w_home_miss;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      start_driving = 1'b0;
      blocked_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_state_nxt = (r_act_steps[30:0] == 31'd0) ? ST_IDLE : ST_ISSUE;
         end
         ST_ISSUE: begin
            start_driving = 1'b1;
            if (stepper_driving)              w_state_nxt = ST_RUN;
            else if (r_ack_cnt <= CW'(1))     w_state_nxt = ST_BLOCK;
         end
         ST_RUN: begin
            start_driving = 1'b1;
            if (!stepper_driving) w_state_nxt = ST_DONE;
         end
         ST_DONE:    w_state_nxt = ST_RELEASE;
         ST_BLOCK: begin
            // Refusal while homing onto an already-pressed zmin is a success.
            blocked_err = ~w_home_hit;
            w_state_nxt = ST_RELEASE;
         end
         ST_RELEASE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_steps <= '0;
         r_act_speed <= '0;
         r_ack_cnt   <= '0;
         r_z         <= '0;
      end else begin
         if (w_pop) begin
            r_act_steps <= w_pop_steps;
            r_act_speed <= w_rd_entry.speed;
         end
         if (r_state == ST_CHECK)
            r_ack_cnt <= CW'(ACK_TIMEOUT);
         else if (r_state == ST_ISSUE && r_ack_cnt != '0)
            r_ack_cnt <= r_ack_cnt - 1'b1;
         if (r_state == ST_DONE) begin
            if (w_home_hit) r_z <= 32'd0;
            else            r_z <= r_z + r_act_steps - stepper_step_out;
         end else if (r_state == ST_BLOCK && w_home_hit) begin
            r_z <= 32'd0;
         end
      end
   end

   assign stepper_step_in = r_act_steps;
   assign stepper_speed   = r_act_speed;
   assign z_position      = r_z;
   assign busy            = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_z_move_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_z_move_sequencer                                              |
// | Scoreboard bench with a behavioural stepper driver model.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_z_move_sequencer;

   localparam int          DEPTH    = 4;
   localparam logic [30:0] HOME_MAX = 31'd200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_steps = '0;
   logic [31:0] cmd_speed = '0;
   logic        cmd_home = 1'b0;
   logic [31:0] stepper_step_in;
   logic [31:0] stepper_speed;
   logic        start_driving;
   logic        stepper_driving;
   logic [31:0] stepper_step_out;
   logic        zmin;
   logic        zmax = 1'b0;
   logic        busy;
   logic [2:0]  fifo_level;
   logic [31:0] z_position;
   logic        blocked_err;
   logic        home_fail;

   z_move_sequencer #(
      .FIFO_DEPTH     (DEPTH),
      .ACK_TIMEOUT    (3),
      .HOME_MAX_STEPS (HOME_MAX)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_steps        (cmd_steps),
      .cmd_speed        (cmd_speed),
      .cmd_home         (cmd_home),
      .stepper_step_in  (stepper_step_in),
      .stepper_speed    (stepper_speed),
      .start_driving    (start_driving),
      .stepper_driving  (stepper_driving),
      .stepper_step_out (stepper_step_out),
      .zmin             (zmin),
      .zmax             (zmax),
      .busy             (busy),
      .fifo_level       (fifo_level),
      .z_position       (z_position),
      .blocked_err      (blocked_err),
      .home_fail        (home_fail)
   );

   always #5 clk = ~clk;

   // Driver model: launches on a fresh start_driving, acks one cycle later,
   // one step per clock, halts on zmin while moving negative.
   logic        drv_active;
   logic        drv_armed;
   logic [31:0] drv_rem;
   int          drv_taken;
   int          zmin_after = -1;
   logic        drv_refuse = 1'b0;

   assign stepper_driving  = drv_active;
   assign stepper_step_out = drv_rem;
   assign zmin = (zmin_after >= 0) && (drv_taken >= zmin_after);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_active <= 1'b0;
         drv_armed  <= 1'b0;
         drv_rem    <= '0;
         drv_taken  <= 0;
      end else if (!drv_active) begin
         if (start_driving && drv_armed && !drv_refuse) begin
            drv_active <= 1'b1;
            drv_armed  <= 1'b0;
            drv_rem    <= stepper_step_in;
            drv_taken  <= 0;
         end else if (!start_driving) begin
            drv_armed <= 1'b1;
         end
      end else begin
         if (drv_rem == 32'd0 || (zmin && drv_rem[31])) begin
            drv_active <= 1'b0;
         end else begin
            drv_rem   <= drv_rem[31] ? drv_rem + 32'd1 : drv_rem - 32'd1;
            drv_taken <= drv_taken + 1;
         end
      end
   end

   typedef struct packed {
      logic [31:0] steps;
      logic [31:0] speed;
   } launch_t;

   typedef struct packed {
      logic        blk;
      logic [31:0] z;
      logic        hf;
   } result_t;

   launch_t launch_q[$];
   result_t result_q[$];
   int      n_tests = 0;
   int      n_fail  = 0;
   int      n_launch = 0;
   int      n_blk_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event required none", name);
   endtask

   // Monitor: launch parameters on start_driving rise; result one cycle
   // after start_driving falls (position is registered out of DONE).
   logic    prev_start = 1'b0;
   logic    fall_pending = 1'b0;
   logic    fall_blk = 1'b0;
   launch_t l_exp;
   result_t r_exp;

   always @(negedge clk) begin
      if (rst_n) begin
         if (blocked_err) n_blk_pulses++;
         if (fall_pending) begin
            fall_pending = 1'b0;
            if (result_q.size() == 0) fail_now("result_unexpected");
            else begin
               r_exp = result_q.pop_front();
               check("res_blocked", {31'd0, fall_blk}, {31'd0, r_exp.blk});
               check("res_z", z_position, r_exp.z);
               check("res_home_fail", {31'd0, home_fail}, {31'd0, r_exp.hf});
            end
         end
         if (start_driving && !prev_start) begin
            n_launch++;
            if (launch_q.size() == 0) fail_now("launch_unexpected");
            else begin
               l_exp = launch_q.pop_front();
               check("launch_steps", stepper_step_in, l_exp.steps);
               check("launch_speed", stepper_speed, l_exp.speed);
            end
         end
         if (!start_driving && prev_start) begin
            fall_pending = 1'b1;
            fall_blk     = blocked_err;
         end
         prev_start = start_driving;
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic expect_move(input logic [31:0] st, input logic [31:0] sp,
                              input logic blk, input logic [31:0] z, input logic hf);
      launch_q.push_back('{steps: st, speed: sp});
      result_q.push_back('{blk: blk, z: z, hf: hf});
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] st, input logic [31:0] sp, input logic hm);
      bit done = 0;
      cmd_steps = st;
      cmd_speed = sp;
      cmd_home  = hm;
      cmd_valid = 1'b1;
      for (int k = 0; k < 400 && !done; k++) begin
         if (cmd_ready) done = 1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!done) fail_now("send_timeout");
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(posedge clk);
         #1;
         if (!busy) done = 1;
      end
      if (!done) fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   int  launches_before;
   bit  seen;
   bit  done;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_start", {31'd0, start_driving}, 32'd0);
      check("rst_z", z_position, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      check("rst_step_in", stepper_step_in, 32'd0);
      check("rst_blocked", {31'd0, blocked_err}, 32'd0);
      check("rst_home_fail", {31'd0, home_fail}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // +100: cmd_valid cycle is cycle 0, start_driving must be high in cycle 3.
      expect_move(32'd100, 32'd2, 1'b0, 32'd100, 1'b0);
      cmd_steps = 32'd100; cmd_speed = 32'd2; cmd_home = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #1; cmd_valid = 1'b0;
      check("t1_level_c1", {29'd0, fifo_level}, 32'd1);
      check("t1_start_c1", {31'd0, start_driving}, 32'd0);
      @(posedge clk); #1;
      check("t1_start_c2", {31'd0, start_driving}, 32'd0);
      @(posedge clk); #1;
      check("t1_start_c3", {31'd0, start_driving}, 32'd1);
      seen = 0; done = 0;
      for (int k = 0; k < 500 && !done; k++) begin
         @(posedge clk); #1;
         if (stepper_driving) seen = 1;
         else if (seen) done = 1;
      end
      if (!done) fail_now("t1_drv_timeout");
      check("t1_start_at_drv_fall", {31'd0, start_driving}, 32'd1);
      @(posedge clk); #1;
      check("t1_start_after_fall", {31'd0, start_driving}, 32'd0);
      wait_idle();

      // -50 with zmin after 20 steps: driver leaves -30 remaining.
      zmin_after = 20;
      expect_move(32'hFFFF_FFCE, 32'd3, 1'b0, 32'd80, 1'b0);
      send(32'hFFFF_FFCE, 32'd3, 1'b0);
      wait_idle();
      check("t2_step_out", stepper_step_out, 32'hFFFF_FFE2);
      zmin_after = -1;

      // Driver refuses (zmax); then a normal command must still run.
      zmax = 1'b1; drv_refuse = 1'b1;
      expect_move(32'd10, 32'd1, 1'b1, 32'd80, 1'b0);
      send(32'd10, 32'd1, 1'b0);
      wait_idle();
      zmax = 1'b0; drv_refuse = 1'b0;
      expect_move(32'd7, 32'd1, 1'b0, 32'd87, 1'b0);
      send(32'd7, 32'd0, 1'b0);
      wait_idle();

      // Long move occupies the FSM while five commands are queued.
      expect_move(32'd30, 32'd1, 1'b0, 32'd117, 1'b0);
      send(32'd30, 32'd1, 1'b0);
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(posedge clk); #1;
         if (stepper_driving) done = 1;
      end
      if (!done) fail_now("t4_run_timeout");
      expect_move(32'd5,         32'd1, 1'b0, 32'd122, 1'b0);
      expect_move(32'hFFFF_FFFD, 32'd2, 1'b0, 32'd119, 1'b0);
      expect_move(32'd12,        32'd3, 1'b0, 32'd131, 1'b0);
      expect_move(32'hFFFF_FFF8, 32'd4, 1'b0, 32'd123, 1'b0);
      expect_move(32'd1,         32'd5, 1'b0, 32'd124, 1'b0);
      send(32'd5, 32'd1, 1'b0);
      send(32'hFFFF_FFFD, 32'd2, 1'b0);
      send(32'd12, 32'd3, 1'b0);
      send(32'hFFFF_FFF8, 32'd4, 1'b0);
      check("t4_ready_full", {31'd0, cmd_ready}, 32'd0);
      check("t4_level_full", {29'd0, fifo_level}, 32'd4);
      send(32'd1, 32'd5, 1'b0);
      wait_idle();

      // Zero-length commands are consumed without a launch.
      launches_before = n_launch;
      send(32'd0, 32'd4, 1'b0);
      send(32'h8000_0000, 32'd4, 1'b0);
      wait_idle();
      check("t5_no_launch", n_launch, launches_before);
      check("t5_z", z_position, 32'd124);

`ifdef Z_HOMING_EN
      expect_move(32'd376, 32'd1, 1'b0, 32'd500, 1'b0);
      send(32'd376, 32'd1, 1'b0);
      wait_idle();
      zmin_after = 40;
      expect_move(32'hFFFF_FF38, 32'd2, 1'b0, 32'd0, 1'b0);
      send(32'd999, 32'd2, 1'b1);
      wait_idle();
      zmin_after = -1;
      expect_move(32'hFFFF_FF38, 32'd2, 1'b0, 32'hFFFF_FF38, 1'b1);
      send(32'd999, 32'd2, 1'b1);
      wait_idle();
      check("t6_home_fail_sticky", {31'd0, home_fail}, 32'd1);
      expect_move(32'd1, 32'd1, 1'b0, 32'hFFFF_FF39, 1'b0);
      send(32'd1, 32'd1, 1'b0);
      wait_idle();
`else
      expect_move(32'd6, 32'd1, 1'b0, 32'd130, 1'b0);
      send(32'd6, 32'd1, 1'b1);
      wait_idle();
`endif

      repeat (3) @(posedge clk);
      #1;
      check("end_launch_q_empty", launch_q.size(), 32'd0);
      check("end_result_q_empty", result_q.size(), 32'd0);
      check("end_blk_pulses", n_blk_pulses, 32'd1);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_level", {29'd0, fifo_level}, 32'd0);

      // Reset mid-move drops start_driving at once and clears position.
      send(32'd50, 32'd1, 1'b0);
      launch_q.push_back('{steps: 32'd50, speed: 32'd1});
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_start", {31'd0, start_driving}, 32'd0);
      check("rstmid_z", z_position, 32'd0);
      check("rstmid_level", {29'd0, fifo_level}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
